// File: rtl/binary_multiplier.sv
// binary_multiplier: sequential radix-2 shift-and-add unsigned multiplier, one multiplier bit per clock.
module binary_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   output logic [2*WIDTH-1:0] result,
   output logic               busy,
   output logic               done
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nxt;
   logic [2*WIDTH-1:0] mcand, acc, sum;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               last;
   // sum includes the current iteration's add so the final result needs no extra cycle
   assign sum  = acc + (mplier[0] ? mcand : '0);
   assign last = cnt == CW'(WIDTH - 1);
   assign busy = state == RUN;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= (state == RUN) && last;
         if (state == IDLE && start) begin
            mcand  <= {{WIDTH{1'b0}}, operand_a};
            mplier <= operand_b;
            acc    <= '0;
            cnt    <= '0;
         end else if (state == RUN) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) result <= sum;
         end
      end
endmodule

// File: tb/tb_binary_multiplier.sv
// tb_binary_multiplier: directed vectors plus a transaction-level model checked every cycle.
module tb_binary_multiplier;
   localparam int WIDTH = 4;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [WIDTH-1:0] operand_a = '0, operand_b = '0;
   logic [2*WIDTH-1:0] result;
   logic busy, done;
   int n_cmp = 0, n_bad = 0, n_done = 0;
   bit chk_en = 1'b0;

   binary_multiplier #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .operand_a(operand_a), .operand_b(operand_b),
      .result(result), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted op completes WIDTH edges later with the plain arithmetic product
   logic [2*WIDTH-1:0] m_res = '0, m_prod = '0;
   logic m_busy = 1'b0, m_done = 1'b0;
   int m_left = 0;
   always @(posedge clk or negedge rst)
      if (!rst) begin
         m_res <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy <= 1'b1;
               m_left <= WIDTH;
               m_prod <= (2*WIDTH)'(operand_a) * (2*WIDTH)'(operand_b);
            end
         end else if (m_left == 1) begin
            m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_prod;
         end else m_left <= m_left - 1;
      end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_result", 32'(result), 32'(m_res));
         chk("model_busy", 32'(busy), 32'(m_busy));
         chk("model_done", 32'(done), 32'(m_done));
      end
      if (done) n_done++;
   end

   // Called at a negedge; returning at the done negedge lets the next call start back-to-back
   task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [2*WIDTH-1:0] exp, input string name);
      int cyc;
      operand_a = a; operand_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({name, "_latency"}, 32'(cyc), 32'd5);
      chk(name, 32'(result), 32'(exp));
   endtask

   initial begin
      int d0;
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      op(4'b1010, 4'b0011, 8'h1E, "single");
      @(negedge clk);
      chk("done_drop", 32'(done), 32'd0);
      chk("hold_result", 32'(result), 32'h1E);
      op(4'b1100, 4'b0011, 8'h24, "b2b_0");
      op(4'b1100, 4'b0101, 8'h3C, "b2b_1");
      op(4'b1111, 4'b0101, 8'h4B, "b2b_2");
      op(4'b1111, 4'b1111, 8'hE1, "max");
      op(4'b0000, 4'b1011, 8'h00, "zero_a");
      op(4'b1011, 4'b0000, 8'h00, "zero_b");
      op(4'b0001, 4'b1001, 8'h09, "one_a");
      @(negedge clk);
      d0 = n_done;
      operand_a = 4'd6; operand_b = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      operand_a = 4'd15; operand_b = 4'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignore", 32'(busy), 32'd1);
      repeat (6) @(negedge clk);
      chk("ignore_result", 32'(result), 32'd42);
      chk("ignore_done_count", 32'(n_done - d0), 32'd1);
      operand_a = 4'd9; operand_b = 4'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      d0 = n_done;
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_abort_result", 32'(result), 32'd0);
      chk("post_abort_busy", 32'(busy), 32'd0);
      chk("post_abort_done_count", 32'(n_done - d0), 32'd0);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            op(4'(a), 4'(b), 8'(a * b), "exh");
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/binary_multiplier.md
Name: binary_multiplier

Overview:
- Sequential unsigned integer multiplier using the radix-2 shift-and-add method. It computes one multiplier bit per clock.
- Operands are captured on a start request. The product appears on a registered result output, with a one-cycle done pulse.
- Used as a small arithmetic unit wherever area is preferred over a single-cycle array multiplier.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock; all state is updated on this edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- start  input  1  request to begin a multiplication; sampled only in IDLE.
- operand_a  input  WIDTH  unsigned multiplicand.
- operand_b  input  WIDTH  unsigned multiplier.
- result  output  2*WIDTH  registered product of the last completed operation.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse marking that result has just been updated.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - state=IDLE; result=0, busy=0, done=0.
  - Internal operand registers, accumulator and bit counter are cleared.
- States are IDLE and RUN.
- IDLE, start=0:
  - Remain in IDLE.
  - result holds its last value.
  - done=0 (done is high only on the cycle after completion; see RUN completion).
- IDLE, start=1 at edge E0:
  - Latch operand_a into the multiplicand register, zero-extended to 2*WIDTH.
  - Latch operand_b into the multiplier shift register.
  - Clear the accumulator and the counter; go to RUN; busy=1.
- RUN, edges E1..EWIDTH, one iteration each:
  - If multiplier LSB=1, add the multiplicand to the accumulator (2*WIDTH-bit add, no overflow possible).
  - Shift the multiplicand left 1; shift the multiplier right 1; increment the counter.
- RUN completion, at edge EWIDTH:
  - result is loaded with the final accumulator value, including the last iteration's add.
  - done=1 and busy=0; return to IDLE.
  - done falls at the next edge.
  - Latency: done is high in the cycle after exactly WIDTH edges following E0; the throughput limit is one operation per WIDTH+1 cycles.
- Boundary conditions:
  - start while busy=1 is ignored; no queuing.
  - Operand changes during RUN have no effect, because the latched values are used.
  - start=1 on the edge where done is high (state is IDLE) is accepted normally: a new E0 starts, done drops, busy rises.
  - result changes only at completion edges or on reset. It is not cleared at start, so it keeps the old product until the new one is ready.
  - Any operand equal to 0 gives result=0.
  - Maximum (2^WIDTH-1)^2 fits without truncation.
  - Reset asserted mid-operation aborts immediately: all outputs go to 0 and no done pulse is produced.
  - Arithmetic is unsigned only; there is no sign handling.

Test Plan:
- Reset then single op: rst low 10ns then high; start with a=4'b1010, b=4'b0011 -> busy high 4 cycles; done one cycle; result=8'h1E (30).
- Back-to-back sequence, start reasserted on each done cycle:
  - 1100x0011 -> 8'h24 (36).
  - 1100x0101 -> 8'h3C (60).
  - 1111x0101 -> 8'h4B (75).
  - No idle gaps are required between operations.
- Extremes:
  - 1111x1111 -> 8'hE1 (225).
  - 0000x1011 -> 8'h00.
  - 1011x0000 -> 8'h00.
  - 0001x1001 -> 8'h09.
- Ignore rules: change operands and pulse start during RUN -> result equals the product of the originally latched operands; no extra done pulse.
- Reset mid-op: assert rst two cycles after start -> result/busy/done go to 0 asynchronously. After release with start=0 the block stays IDLE with result=0.
- Exhaustive: all 256 (a,b) pairs for WIDTH=4 -> result==a*b, each exactly 5 cycles from the start edge to the done cycle.
